// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath sizes, ALU control encodings and register address type.
package cpu_pkg;

    localparam int WIDTH = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    // Encodings must line up with the ALU's alu_cntr decoding.
    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_NOR  = 2'b10,
        ALU_SLTU = 2'b11
    } alu_op_t;

    typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_2r1w.sv
// 2-read/1-write MIPS register file with $0 hardwired to zero and asynchronous clear.
// Optional write-through forwarding on the read ports: OPERAND_FETCH_WRITE_BYPASS_EN.
module regfile_2r1w
    import cpu_pkg::*;
#(
    parameter int WIDTH = cpu_pkg::WIDTH,
    parameter int NREGS = cpu_pkg::NREGS,
    parameter int AW    = cpu_pkg::AW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [AW-1:0]    raddrA_i,
    input  logic [AW-1:0]    raddrB_i,
    output logic [WIDTH-1:0] rdataA_o,
    output logic [WIDTH-1:0] rdataB_o,
    input  logic             wrEn_i,
    input  logic [AW-1:0]    wrAddr_i,
    input  logic [WIDTH-1:0] wrData_i
);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic             wrLive;

    assign wrLive = wrEn_i && (wrAddr_i != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wrLive) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    // Address 0 is gated on read as well, so $0 is zero regardless of storage contents.
    always_comb begin
        rdataA_o = (raddrA_i == '0) ? '0 : mem_q[raddrA_i];
        rdataB_o = (raddrB_i == '0) ? '0 : mem_q[raddrB_i];
`ifdef OPERAND_FETCH_WRITE_BYPASS_EN
        if (wrLive && (wrAddr_i == raddrA_i)) begin
            rdataA_o = wrData_i;
        end
        if (wrLive && (wrAddr_i == raddrB_i)) begin
            rdataB_o = wrData_i;
        end
`endif
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register file read plus the output register feeding the ALU.
// Build option OPERAND_FETCH_WRITE_BYPASS_EN enables same-cycle writeback forwarding.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int WIDTH = cpu_pkg::WIDTH,
    parameter int NREGS = cpu_pkg::NREGS,
    parameter int AW    = cpu_pkg::AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    rs,
    input  logic [AW-1:0]    rt,
    input  logic [1:0]       alu_op,
    input  logic             stall,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] bus_a,
    output logic [WIDTH-1:0] bus_b,
    output logic [1:0]       alu_cntr
);

    logic [WIDTH-1:0] readA;
    logic [WIDTH-1:0] readB;

    logic             outValid_q, outValid_d;
    logic [WIDTH-1:0] busA_q, busA_d;
    logic [WIDTH-1:0] busB_q, busB_d;
    alu_op_t          aluCntr_q, aluCntr_d;

    regfile_2r1w #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regfile (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .raddrA_i (rs),
        .raddrB_i (rt),
        .rdataA_o (readA),
        .rdataB_o (readB),
        .wrEn_i   (wr_en),
        .wrAddr_i (wr_addr),
        .wrData_i (wr_data)
    );

    assign in_ready = !stall;

    // Priority: flush, then stall, then load; data fields hold on flush and bubbles.
    always_comb begin
        outValid_d = outValid_q;
        busA_d     = busA_q;
        busB_d     = busB_q;
        aluCntr_d  = aluCntr_q;
        if (flush) begin
            outValid_d = 1'b0;
        end else if (stall) begin
            outValid_d = outValid_q;
        end else if (in_valid) begin
            outValid_d = 1'b1;
            busA_d     = readA;
            busB_d     = readB;
            aluCntr_d  = alu_op_t'(alu_op);
        end else begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            busA_q     <= '0;
            busB_q     <= '0;
            aluCntr_q  <= ALU_ADD;
        end else begin
            outValid_q <= outValid_d;
            busA_q     <= busA_d;
            busB_q     <= busB_d;
            aluCntr_q  <= aluCntr_d;
        end
    end

    assign out_valid = outValid_q;
    assign bus_a     = busA_q;
    assign bus_b     = busB_q;
    assign alu_cntr  = aluCntr_q;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand stage directly upstream of the 32-bit ALU.
- Holds the 32x32 MIPS register file: 2 read ports, 1 write port, and $0 hardwired to zero.
- Captures the two source operands and the 2-bit ALU control into an output register that drives the ALU's bus_a, bus_b and alu_cntr.
- Valid/ready handshake, stall and flush for the pipeline.

Parameters:
- WIDTH, 32, data width of registers and operands
- NREGS, 32, number of architectural registers (register 0 reads as zero)
- AW, 5, register address width, equal to log2(NREGS)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents an instruction's rs/rt/alu_op
- in_ready  output  1  stage can accept; equals !stall
- rs  input  AW  source register A address
- rt  input  AW  source register B address
- alu_op  input  2  ALU operation code, passed through to alu_cntr
- stall  input  1  hold output register contents
- flush  input  1  invalidate output register
- wr_en  input  1  writeback enable
- wr_addr  input  AW  writeback register address
- wr_data  input  WIDTH  writeback data
- out_valid  output  1  bus_a/bus_b/alu_cntr hold a valid operation
- bus_a  output  WIDTH  operand A to ALU
- bus_b  output  WIDTH  operand B to ALU
- alu_cntr  output  2  ALU control to ALU

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n=0:
  - all register-file entries are 0
  - out_valid=0, bus_a=0, bus_b=0, alu_cntr=2'b00
  - Release is synchronous to the next clk edge.
- Reset mid-operation: any in-flight output is discarded and any same-cycle write is lost.
- Register file reads: combinational from rs/rt. Address 0 always returns 0.
- Register file writes: on a rising edge when wr_en=1 and wr_addr!=0, wr_data is stored. Writes to address 0 are discarded.
- Writes are independent of stall, flush and in_valid.
- Same-cycle read of the address being written returns the OLD value (see optional feature).
- Output register update at each rising edge, in priority order:
  1. flush=1: out_valid<=0. Data fields may update or hold but must not be relied on. Flush overrides stall and load.
  2. stall=1: all outputs hold their current values.
  3. in_valid=1: bus_a<=read(rs), bus_b<=read(rt), alu_cntr<=alu_op, out_valid<=1.
  4. Otherwise: out_valid<=0, data fields hold.
- in_ready=!stall, combinational. A transfer occurs only when in_valid && in_ready && !flush.
- Latency: one cycle from accepted rs/rt to the operand on bus_a/bus_b.
- Write-to-read visibility: a value written at edge N is visible to a read accepted at edge N+1 or later.
- No arithmetic is performed. Operands are passed bit-exact. The sign/negation for subtract is done in the ALU.
- Out-of-range addresses are impossible when NREGS = 2**AW. No other checks.

Optional Feature:
- Macro: OPERAND_FETCH_WRITE_BYPASS_EN
- Defined: if wr_en=1, wr_addr!=0 and wr_addr==rs (or rt) in the cycle the operand is loaded, the loaded operand is wr_data (write-through forwarding). Address 0 still yields 0.
- Undefined: the old register contents are loaded, per the base rules. Writeback-to-read hazards are then handled by the pipeline's hazard logic via stall.

Decomposition:
- Shared package cpu_pkg holds:
  - WIDTH/AW/NREGS constants
  - a 2-bit alu_op typedef with named encodings matching the ALU's alu_cntr (ADD, SUB, NOR, SLTU)
  - a reg_addr_t typedef
- One natural sub-module: regfile_2r1w (storage, $0 rule, async reset, optional bypass mux).
- The output register and handshake logic stay in operand_fetch.

Test Plan:
- Reset: assert rst_n=0 mid-run with out_valid=1 -> outputs immediately 0. After release, reading rs=5/rt=9 gives bus_a=0, bus_b=0.
- Write/read: write r3=32'h1234_5678, then next cycle rs=3, rt=0, alu_op=2'b01, in_valid=1 -> one cycle later bus_a=32'h1234_5678, bus_b=0, alu_cntr=01, out_valid=1.
- $0 protection: wr_en=1, wr_addr=0, wr_data=32'hFFFF_FFFF; then rs=0 -> bus_a=0.
- Stall/flush: load r3/r4, hold stall=1 for 3 cycles while changing rs/rt -> outputs unchanged and in_ready=0. Then flush=1 together with stall=1 -> out_valid=0 next cycle.
- Same-cycle write/read: r7=32'hA, same cycle write r7=32'hB and load rs=7 -> bus_a=32'hA without the macro, 32'hB with OPERAND_FETCH_WRITE_BYPASS_EN. The following load gives 32'hB in both builds.
- Bubble: in_valid=0, stall=0 -> out_valid=0 next cycle and bus_a/bus_b keep their previous values.
